// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: a DEPTH-entry character FIFO feeding a dispatch FSM
// that hands one character at a time to the TX FSM controller.
package uart_package;
    localparam int DATA_WIDTH = 8;
endpackage

module uart_tx_fifo #(
    parameter int DATA_WIDTH   = uart_package::DATA_WIDTH,
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow,
    input  logic                    i_tx_busy,
    output logic                    o_Data_Valid,
    output logic [DATA_WIDTH-1:0]   o_P_DATA,
    output logic                    o_timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic [TW-1:0]          timer;
    logic [TW-1:0]          timer_nxt;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   timeout_hit;

    // Flags come straight from the registered occupancy, never from i_wr_en.
    assign o_count = count;
    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);

    // A pop frees a slot in the same cycle, so a write into a full FIFO is
    // still accepted when the dispatcher is loading the head entry.
    always_comb begin
        pop  = (state == S_IDLE) && !o_empty && !i_tx_busy;
        push = i_wr_en && (!o_full || pop);
        drop = i_wr_en && o_full && !pop;
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            timer         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_overflow    <= 1'b0;
            o_timeout_err <= 1'b0;
            o_P_DATA      <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                o_P_DATA <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end
            if (timeout_hit) begin
                o_timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        timeout_hit  = 1'b0;
        o_Data_Valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_Data_Valid = 1'b1;
                timer_nxt    = '0;
                state_nxt    = S_WAIT_BUSY;
            end
            // Give the controller BUSY_TIMEOUT cycles to acknowledge the pulse.
            S_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo with a queue-based reference
// model and a small TX-controller model that answers each start pulse.
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int TO    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          empty;
    logic [3:0]    count;
    logic          overflow;
    logic          tx_busy;
    logic          data_valid;
    logic [DW-1:0] p_data;
    logic          timeout_err;

    logic busy_model;
    logic busy_force;
    bit   busy_respond;
    bit   busy_active;
    int   busy_delay;
    int   busy_hold;

    assign tx_busy = busy_model | busy_force;

    uart_tx_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_en      (wr_en),
        .i_wr_data    (wr_data),
        .o_full       (full),
        .o_empty      (empty),
        .o_count      (count),
        .o_overflow   (overflow),
        .i_tx_busy    (tx_busy),
        .o_Data_Valid (data_valid),
        .o_P_DATA     (p_data),
        .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    // Reference model state: pending characters in FIFO order plus sticky flags.
    logic [DW-1:0] model_q[$];
    bit            exp_ovf;
    bit            exp_to;
    bit            to_pending;
    bit            waiting;
    int            wait_cnt;
    logic [DW-1:0] last_pdata;
    bit            prev_valid;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: captures what the DUT sampled at each rising edge and
    // checks the resulting outputs half a cycle later.
    initial begin : monitor
        bit            s_rst;
        bit            s_wr;
        bit            s_full;
        logic [DW-1:0] s_data;
        forever begin
            @(posedge clk);
            s_rst  = rst;
            s_wr   = wr_en;
            s_data = wr_data;
            s_full = (model_q.size() == DEPTH);
            @(negedge clk);
            if (s_rst) begin
                model_q.delete();
                exp_ovf    = 1'b0;
                exp_to     = 1'b0;
                to_pending = 1'b0;
                waiting    = 1'b0;
                wait_cnt   = 0;
                last_pdata = '0;
                check("rst_valid", int'(data_valid), 0);
            end else begin
                if (to_pending) begin
                    exp_to     = 1'b1;
                    to_pending = 1'b0;
                end
                if (waiting) begin
                    if (tx_busy) begin
                        waiting = 1'b0;
                    end else begin
                        wait_cnt++;
                        if (wait_cnt == TO) begin
                            waiting    = 1'b0;
                            to_pending = 1'b1;
                        end
                    end
                end
                if (data_valid) begin
                    check("no_back_to_back", int'(prev_valid), 0);
                    check("pulse_while_busy", int'(tx_busy), 0);
                    check("pulse_has_data", int'(model_q.size() != 0), 1);
                    if (model_q.size() != 0) begin
                        last_pdata = model_q.pop_front();
                    end
                    pulses++;
                    waiting  = 1'b1;
                    wait_cnt = 0;
                end
                if (s_wr) begin
                    if (!s_full || data_valid) begin
                        model_q.push_back(s_data);
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            end
            check("p_data", int'(p_data), int'(last_pdata));
            check("count", int'(count), model_q.size());
            check("full", int'(full), int'(model_q.size() == DEPTH));
            check("empty", int'(empty), int'(model_q.size() == 0));
            check("overflow", int'(overflow), int'(exp_ovf));
            check("timeout_err", int'(timeout_err), int'(exp_to));
            prev_valid = data_valid;
        end
    end

    // TX controller model: raise busy busy_delay cycles after a pulse, hold it busy_hold cycles.
    initial begin : busy_proc
        int d;
        int h;
        busy_model  = 1'b0;
        busy_active = 1'b0;
        forever begin
            @(negedge clk);
            if (data_valid && busy_respond) begin
                busy_active = 1'b1;
                d = busy_delay;
                h = busy_hold;
                repeat (d) @(posedge clk);
                #1 busy_model = 1'b1;
                repeat (h) @(posedge clk);
                #1 busy_model = 1'b0;
                busy_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation still running at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic write_char(input logic [DW-1:0] d);
        @(posedge clk);
        #1 wr_en = 1'b1;
        wr_data = d;
    endtask

    task automatic stop_write();
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((model_q.size() != 0 || busy_active || waiting || to_pending) && n < limit) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check("drain_empty", model_q.size(), 0);
        check("drain_in_time", int'(n < limit), 1);
    endtask

    task automatic wait_pulse(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (data_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("pulse_seen", int'(ok), 1);
    endtask

    initial begin : main
        bit ok;
        int p0;
        rst          = 1'b1;
        wr_en        = 1'b0;
        wr_data      = '0;
        busy_force   = 1'b0;
        busy_respond = 1'b1;
        busy_delay   = 2;
        busy_hold    = 3;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_p_data", int'(p_data), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_full", int'(full), 0);

        // Single character into an idle path: pulse in the third cycle counting the write cycle.
        write_char(8'hA5);
        stop_write();
        @(negedge clk);
        check("a5_no_early_pulse", int'(data_valid), 0);
        check("a5_visible", int'(count), 1);
        @(negedge clk);
        check("a5_pulse", int'(data_valid), 1);
        check("a5_p_data", int'(p_data), 'hA5);
        check("a5_count", int'(count), 0);
        @(negedge clk);
        check("a5_single_pulse", int'(data_valid), 0);
        drain(100);

        // Nine writes with TX held busy: ninth is dropped.
        @(posedge clk);
        #1 busy_force = 1'b1;
        for (int i = 0; i < 9; i++) begin
            write_char(DW'($urandom));
        end
        @(negedge clk);
        check("fill_full_after_8", int'(full), 1);
        check("fill_no_ovf_yet", int'(overflow), 0);
        stop_write();
        @(negedge clk);
        check("fill_overflow", int'(overflow), 1);
        check("fill_count", int'(count), 8);

        // Full FIFO plus a write on the pop cycle: accepted, no overflow.
        pulse_rst();
        for (int i = 0; i < 8; i++) begin
            write_char(DW'($urandom));
        end
        stop_write();
        @(negedge clk);
        check("refill_full", int'(full), 1);
        @(posedge clk);
        #1 busy_force = 1'b0;
        wr_en   = 1'b1;
        wr_data = DW'($urandom);
        stop_write();
        @(negedge clk);
        check("pop_write_pulse", int'(data_valid), 1);
        check("pop_write_count", int'(count), 8);
        check("pop_write_no_ovf", int'(overflow), 0);
        drain(400);

        // Three characters, busy rising 2 cycles after each pulse, held 11 cycles.
        busy_delay = 2;
        busy_hold  = 11;
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            write_char(DW'($urandom));
        end
        stop_write();
        drain(300);
        check("three_pulses", pulses - p0, 3);

        // Controller never answers: timeout after BUSY_TIMEOUT cycles, then next character.
        busy_respond = 1'b0;
        write_char(8'h3C);
        write_char(8'hC3);
        stop_write();
        wait_pulse(20, ok);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("timeout_not_yet", int'(timeout_err), 0);
        end
        @(negedge clk);
        check("timeout_set", int'(timeout_err), 1);
        @(negedge clk);
        check("timeout_next_pulse", int'(data_valid), 1);
        check("timeout_next_data", int'(p_data), 'hC3);
        drain(100);
        busy_respond = 1'b1;

        // Reset while waiting for busy to fall with three entries queued.
        busy_delay = 1;
        busy_hold  = 30;
        for (int i = 0; i < 4; i++) begin
            write_char(DW'($urandom));
        end
        stop_write();
        repeat (4) @(negedge clk);
        check("midxfer_busy", int'(tx_busy), 1);
        check("midxfer_count", int'(count), 3);
        pulse_rst();
        @(negedge clk);
        check("midxfer_rst_count", int'(count), 0);
        check("midxfer_rst_empty", int'(empty), 1);
        check("midxfer_rst_valid", int'(data_valid), 0);
        check("midxfer_rst_ovf", int'(overflow), 0);
        check("midxfer_rst_to", int'(timeout_err), 0);
        drain(100);

        // Random traffic with random controller response times.
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            busy_delay = int'($urandom_range(1, 5));
            busy_hold  = int'($urandom_range(1, 6));
            wr_en      = ($urandom_range(0, 99) < 45);
            wr_data    = DW'($urandom);
        end
        stop_write();
        drain(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
